// File: rtl/ip_udp_packet_rx.sv
`default_nettype none
// ============================================================================
// Module   : ip_udp_packet_rx
// Purpose  : Ethernet/IPv4/UDP frame receiver with filtering, IPv4 header
//            checksum check, payload capture and drop statistics.
// Revision : 1.0 - initial release
// ============================================================================
module ip_udp_packet_rx #(
    parameter int BEAT_BYTES        = 1,
    parameter int MAX_PAYLOAD_BYTES = 785,
    parameter int COUNTER_WIDTH     = 16,
    parameter int LEN_WIDTH         = $clog2(MAX_PAYLOAD_BYTES + 1)
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [31:0]                    ACCELERATOR_IP_ADDRESS,
    input  logic [47:0]                    ACCELERATOR_MAC_ADDRESS,
    input  logic [15:0]                    ACCELERATOR_UDP_PORT,
    input  logic [8*BEAT_BYTES-1:0]        MAC_DATA_OUT,
    input  logic [BEAT_BYTES-1:0]          MAC_DATA_KEEP,
    input  logic                           MAC_DATA_VALID,
    output logic                           MAC_DATA_READY,
    input  logic                           MAC_DATA_LAST,
    input  logic                           MAC_DATA_TUSER,
    output logic [8*MAX_PAYLOAD_BYTES-1:0] DATA_FRAME,
    output logic [LEN_WIDTH-1:0]           PAYLOAD_BYTES,
    output logic [31:0]                    SRC_IP_ADDRESS,
    output logic [47:0]                    SRC_MAC_ADDRESS,
    output logic [15:0]                    SRC_UDP_PORT,
    output logic                           FRAME_VALID,
    input  logic                           FRAME_READY,
    output logic                           DROP,
    output logic [2:0]                     DROP_REASON,
    output logic [COUNTER_WIDTH-1:0]       ACCEPT_COUNT,
    output logic [COUNTER_WIDTH-1:0]       DROP_COUNT
);
    localparam int HDR        = 42;
    localparam int BC_MAX     = HDR + MAX_PAYLOAD_BYTES;
    localparam int BC_WIDTH   = $clog2(BC_MAX + 1);
    localparam int IDX_WIDTH  = BC_WIDTH + 4;
    localparam int PIDX_WIDTH = (MAX_PAYLOAD_BYTES > 1) ? $clog2(MAX_PAYLOAD_BYTES) : 1;
    localparam int KW         = $clog2(BEAT_BYTES + 1);
    localparam logic [IDX_WIDTH-1:0] HDR_I    = IDX_WIDTH'(HDR);
    localparam logic [IDX_WIDTH-1:0] BCMAX_I  = IDX_WIDTH'(BC_MAX);

    typedef enum logic [1:0] {
        S_RECV  = 2'd0,
        S_CHECK = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                    pipe_vld_q, pipe_last_q, pipe_tuser_q;
    logic [8*BEAT_BYTES-1:0] pipe_data_q;
    logic [BEAT_BYTES-1:0]   pipe_keep_q;
    logic [BC_WIDTH-1:0]     bc_q, bc_d;
    logic                    tuser_q;
    logic [7:0]              hdr_q     [HDR];
    logic [7:0]              payload_q [MAX_PAYLOAD_BYTES];
    logic [LEN_WIDTH-1:0]    payload_bytes_q;
    logic [31:0]             src_ip_q;
    logic [47:0]             src_mac_q;
    logic [15:0]             src_port_q;
    logic [2:0]              drop_reason_q;
    logic [COUNTER_WIDTH-1:0] accept_cnt_q, drop_cnt_q;

    logic beat_acc, fail, clear_frame;
    logic [2:0] reason;

    // The LAST beat waits one cycle in the input register, so stall behind it.
    assign MAC_DATA_READY = (state_q == S_RECV) && !(pipe_vld_q && pipe_last_q);
    assign beat_acc       = MAC_DATA_VALID && MAC_DATA_READY;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            pipe_vld_q   <= 1'b0;
            pipe_last_q  <= 1'b0;
            pipe_tuser_q <= 1'b0;
            pipe_data_q  <= '0;
            pipe_keep_q  <= '0;
        end else begin
            pipe_vld_q   <= beat_acc;
            pipe_last_q  <= beat_acc && MAC_DATA_LAST;
            pipe_tuser_q <= MAC_DATA_TUSER;
            pipe_data_q  <= MAC_DATA_OUT;
            pipe_keep_q  <= MAC_DATA_KEEP;
        end
    end

    logic [IDX_WIDTH-1:0]  lane_idx [BEAT_BYTES];
    logic [PIDX_WIDTH-1:0] pay_off  [BEAT_BYTES];
    logic [KW-1:0]         keep_cnt;
    logic [IDX_WIDTH-1:0]  bc_sum;

    always_comb begin
        keep_cnt = '0;
        for (int k = 0; k < BEAT_BYTES; k++) begin
            lane_idx[k] = IDX_WIDTH'(bc_q) + IDX_WIDTH'(k);
            pay_off[k]  = PIDX_WIDTH'(lane_idx[k] - HDR_I);
            keep_cnt    = keep_cnt + KW'(pipe_keep_q[k]);
        end
        bc_sum = IDX_WIDTH'(bc_q) + IDX_WIDTH'(keep_cnt);
        bc_d   = (bc_sum > BCMAX_I) ? BC_WIDTH'(BC_MAX) : BC_WIDTH'(bc_sum);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET || clear_frame) begin
            for (int i = 0; i < MAX_PAYLOAD_BYTES; i++) payload_q[i] <= 8'h00;
        end else if (pipe_vld_q) begin
            for (int k = 0; k < BEAT_BYTES; k++) begin
                if (pipe_keep_q[k] && lane_idx[k] < HDR_I)
                    hdr_q[6'(lane_idx[k])] <= pipe_data_q[8*k +: 8];
                else if (pipe_keep_q[k] && lane_idx[k] < BCMAX_I)
                    payload_q[pay_off[k]] <= pipe_data_q[8*k +: 8];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET || clear_frame) begin
            bc_q    <= '0;
            tuser_q <= 1'b0;
        end else if (pipe_vld_q) begin
            bc_q <= bc_d;
            if (pipe_last_q) tuser_q <= pipe_tuser_q;
        end
    end

    logic [47:0] dst_mac, src_mac;
    logic [31:0] dst_ip, src_ip;
    logic [15:0] total_len, udp_len, src_port, dst_port;
    logic [19:0] csum_acc;
    logic [16:0] csum_f1;
    logic [15:0] csum_f2;
    logic        len_bad;

    assign dst_mac   = {hdr_q[5], hdr_q[4], hdr_q[3], hdr_q[2], hdr_q[1], hdr_q[0]};
    assign src_mac   = {hdr_q[11], hdr_q[10], hdr_q[9], hdr_q[8], hdr_q[7], hdr_q[6]};
    assign total_len = {hdr_q[16], hdr_q[17]};
    assign src_ip    = {hdr_q[29], hdr_q[28], hdr_q[27], hdr_q[26]};
    assign dst_ip    = {hdr_q[33], hdr_q[32], hdr_q[31], hdr_q[30]};
    assign src_port  = {hdr_q[35], hdr_q[34]};
    assign dst_port  = {hdr_q[37], hdr_q[36]};
    assign udp_len   = {hdr_q[38], hdr_q[39]};

    always_comb begin
        csum_acc = '0;
        for (int j = 0; j < 10; j++)
            csum_acc = csum_acc + {4'h0, hdr_q[14+2*j], hdr_q[15+2*j]};
    end
    assign csum_f1 = {1'b0, csum_acc[15:0]} + {13'd0, csum_acc[19:16]};
    assign csum_f2 = csum_f1[15:0] + {15'd0, csum_f1[16]};

    // The frame must carry the whole IP datagram behind the 14 B Ethernet header.
    assign len_bad = (total_len < 16'd28)
                  || ((total_len - 16'd28) > 16'(MAX_PAYLOAD_BYTES))
                  || (17'(bc_q) < (17'(total_len) + 17'd14))
                  || (udp_len != (total_len - 16'd20));

    always_comb begin
        fail   = 1'b1;
        reason = 3'd0;
        if (tuser_q)                                         reason = 3'd1;
        else if (bc_q < BC_WIDTH'(HDR))                      reason = 3'd2;
        else if (!(dst_mac == ACCELERATOR_MAC_ADDRESS || dst_mac == 48'hFFFF_FFFF_FFFF))
                                                             reason = 3'd3;
        else if (hdr_q[14] != 8'h45 || hdr_q[23] != 8'h11)   reason = 3'd4;
        else if (dst_ip != ACCELERATOR_IP_ADDRESS)           reason = 3'd5;
        else if (csum_f2 != 16'hFFFF)                        reason = 3'd6;
        else if (dst_port != ACCELERATOR_UDP_PORT)           reason = 3'd7;
        else if (len_bad)                                    reason = 3'd0;
        else                                                 fail   = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RECV:  if (pipe_vld_q && pipe_last_q) state_d = S_CHECK;
            S_CHECK: state_d = fail ? S_RECV : S_HOLD;
            S_HOLD:  if (FRAME_READY) state_d = S_RECV;
            default: state_d = S_RECV;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) state_q <= S_RECV;
        else        state_q <= state_d;
    end

    assign clear_frame = ((state_q == S_CHECK) && fail) || ((state_q == S_HOLD) && FRAME_READY);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            payload_bytes_q <= '0;
            src_ip_q        <= '0;
            src_mac_q       <= '0;
            src_port_q      <= '0;
            drop_reason_q   <= 3'd0;
            accept_cnt_q    <= '0;
            drop_cnt_q      <= '0;
        end else begin
            if (state_q == S_CHECK && !fail) begin
                payload_bytes_q <= LEN_WIDTH'(total_len - 16'd28);
                src_ip_q        <= src_ip;
                src_mac_q       <= src_mac;
                src_port_q      <= src_port;
            end
            if (state_q == S_CHECK && fail) begin
                drop_reason_q <= reason;
                drop_cnt_q    <= drop_cnt_q + COUNTER_WIDTH'(1);
            end
            if (state_q == S_HOLD && FRAME_READY)
                accept_cnt_q <= accept_cnt_q + COUNTER_WIDTH'(1);
        end
    end

    assign FRAME_VALID     = (state_q == S_HOLD);
    assign DROP            = (state_q == S_CHECK) && fail;
    assign DROP_REASON     = DROP ? reason : drop_reason_q;
    assign PAYLOAD_BYTES   = payload_bytes_q;
    assign SRC_IP_ADDRESS  = src_ip_q;
    assign SRC_MAC_ADDRESS = src_mac_q;
    assign SRC_UDP_PORT    = src_port_q;
    assign ACCEPT_COUNT    = accept_cnt_q;
    assign DROP_COUNT      = drop_cnt_q;

    // Padding lands in the capture buffer too; mask everything past the length.
    for (genvar i = 0; i < MAX_PAYLOAD_BYTES; i++) begin : g_frame
        assign DATA_FRAME[i*8 +: 8] =
            (FRAME_VALID && (LEN_WIDTH'(i) < payload_bytes_q)) ? payload_q[i] : 8'h00;
    end

endmodule
`default_nettype wire
